// File: rtl/button_conditioner_if.sv
// Pin-to-core button signal bundle: raw pin in, conditioned level/strobes/counter out.
interface button_conditioner_if #(
   parameter int unsigned COUNT_WIDTH = 8
);
   logic                   BUTTON;
   logic                   LEVEL;
   logic                   PRESS_PULSE;
   logic                   RELEASE_PULSE;
   logic                   LONG_PRESS;
   logic [COUNT_WIDTH-1:0] PRESS_COUNT;

   // master: board/pin side that drives the raw button and consumes the results
   modport master (
      output BUTTON,
      input  LEVEL,
      input  PRESS_PULSE,
      input  RELEASE_PULSE,
      input  LONG_PRESS,
      input  PRESS_COUNT
   );

   // slave: the conditioner itself
   modport slave (
      input  BUTTON,
      output LEVEL,
      output PRESS_PULSE,
      output RELEASE_PULSE,
      output LONG_PRESS,
      output PRESS_COUNT
   );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises and debounces the raw BUTTON pin; produces a clean level, press/release
// strobes, a long-press flag and a wrapping press counter.
module button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES   = 500_000,
   parameter int unsigned LONG_PRESS_CYCLES = 20_000_000,
   parameter int unsigned COUNT_WIDTH       = 8
) (
   input  logic                CLK,
   input  logic                RESET,
   button_conditioner_if.slave btn
);

   localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

   localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);

   typedef enum logic [1:0] {
      RELEASED        = 2'd0,
      CONFIRM_PRESS   = 2'd1,
      PRESSED         = 2'd2,
      CONFIRM_RELEASE = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
   logic                   s1_q, s2_q;
   logic                   accept_press, accept_release;

   logic                   level_q, level_d;
   logic                   press_pulse_q, press_pulse_d;
   logic                   release_pulse_q, release_pulse_d;
   logic                   long_press_q, long_press_d;
   logic [COUNT_WIDTH-1:0] press_count_q, press_count_d;
   logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;

   // Two-flop synchroniser for the asynchronous pin
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= btn.BUTTON;
         s2_q <= s1_q;
      end
   end

   // FSM state and debounce counter register
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= RELEASED;
         db_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   // Next-state: any sample disagreeing with the candidate level aborts the confirm phase
   always_comb begin
      state_d        = state_q;
      db_cnt_d       = db_cnt_q;
      accept_press   = 1'b0;
      accept_release = 1'b0;
      case (state_q)
         RELEASED: begin
            if (s2_q) begin
               state_d  = CONFIRM_PRESS;
               db_cnt_d = DB_W'(1);
            end
         end
         CONFIRM_PRESS: begin
            if (!s2_q) begin
               state_d  = RELEASED;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d      = PRESSED;
               db_cnt_d     = '0;
               accept_press = 1'b1;
            end else begin
               db_cnt_d = db_cnt_q + DB_W'(1);
            end
         end
         PRESSED: begin
            if (!s2_q) begin
               state_d  = CONFIRM_RELEASE;
               db_cnt_d = DB_W'(1);
            end
         end
         CONFIRM_RELEASE: begin
            if (s2_q) begin
               state_d  = PRESSED;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d        = RELEASED;
               db_cnt_d       = '0;
               accept_release = 1'b1;
            end else begin
               db_cnt_d = db_cnt_q + DB_W'(1);
            end
         end
         default: begin
            state_d  = RELEASED;
            db_cnt_d = '0;
         end
      endcase
   end

   // Output next-values; release accept overrides any long-press assertion on the same edge
   always_comb begin
      level_d         = level_q;
      press_pulse_d   = accept_press;
      release_pulse_d = accept_release;
      long_press_d    = long_press_q;
      press_count_d   = press_count_q;
      hold_cnt_d      = hold_cnt_q;
      if (accept_press) begin
         level_d       = 1'b1;
         press_count_d = press_count_q + COUNT_WIDTH'(1);
         hold_cnt_d    = '0;
      end else if (level_q && (hold_cnt_q != HOLD_MAX)) begin
         hold_cnt_d = hold_cnt_q + HOLD_W'(1);
         if (hold_cnt_d == HOLD_MAX) begin
            long_press_d = 1'b1;
         end
      end
      if (accept_release) begin
         level_d      = 1'b0;
         long_press_d = 1'b0;
      end
   end

   // Registered outputs
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         level_q         <= 1'b0;
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         long_press_q    <= 1'b0;
         press_count_q   <= '0;
         hold_cnt_q      <= '0;
      end else begin
         level_q         <= level_d;
         press_pulse_q   <= press_pulse_d;
         release_pulse_q <= release_pulse_d;
         long_press_q    <= long_press_d;
         press_count_q   <= press_count_d;
         hold_cnt_q      <= hold_cnt_d;
      end
   end

   assign btn.LEVEL         = level_q;
   assign btn.PRESS_PULSE   = press_pulse_q;
   assign btn.RELEASE_PULSE = release_pulse_q;
   assign btn.LONG_PRESS    = long_press_q;
   assign btn.PRESS_COUNT   = press_count_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner (DEBOUNCE=4, LONG=10, COUNT_WIDTH=2).
module tb_button_conditioner;

   logic CLK   = 1'b0;
   logic RESET = 1'b1;
   int   vectors = 0;
   int   errors  = 0;

   button_conditioner_if #(.COUNT_WIDTH(2)) bif ();

   button_conditioner #(
      .DEBOUNCE_CYCLES  (4),
      .LONG_PRESS_CYCLES(10),
      .COUNT_WIDTH      (2)
   ) dut (
      .CLK  (CLK),
      .RESET(RESET),
      .btn  (bif)
   );

   always #5 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset;
      bif.BUTTON = 1'b0;
      RESET = 1'b0;
      tick();
      tick();
      RESET = 1'b1;
      tick();
   endtask

   // BUTTON high at edge 0; returns after edge 5, when LEVEL has just risen
   task automatic press;
      bif.BUTTON = 1'b1;
      repeat (6) tick();
   endtask

   task automatic test_reset;
      bif.BUTTON = 1'b1;
      #2 RESET = 1'b0;
      #1;
      vectors++;
      if ({bif.LEVEL, bif.PRESS_PULSE, bif.RELEASE_PULSE, bif.LONG_PRESS, bif.PRESS_COUNT} !== 6'b0) begin
         errors++;
         $display("FAIL reset_async: outputs=%b required=000000",
                  {bif.LEVEL, bif.PRESS_PULSE, bif.RELEASE_PULSE, bif.LONG_PRESS, bif.PRESS_COUNT});
      end
      repeat (8) tick();
      vectors++;
      if ({bif.LEVEL, bif.PRESS_PULSE, bif.RELEASE_PULSE, bif.LONG_PRESS, bif.PRESS_COUNT} !== 6'b0) begin
         errors++;
         $display("FAIL reset_held: outputs=%b required=000000",
                  {bif.LEVEL, bif.PRESS_PULSE, bif.RELEASE_PULSE, bif.LONG_PRESS, bif.PRESS_COUNT});
      end
      bif.BUTTON = 1'b0;
      RESET = 1'b1;
      tick();
   endtask

   task automatic test_clean_press;
      do_reset();
      bif.BUTTON = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if ({bif.LEVEL, bif.PRESS_PULSE} !== 2'b00) begin
            errors++;
            $display("FAIL press_early edge%0d: level,pulse=%b required=00", i, {bif.LEVEL, bif.PRESS_PULSE});
         end
      end
      tick();
      vectors++;
      if ({bif.LEVEL, bif.PRESS_PULSE, bif.RELEASE_PULSE, bif.PRESS_COUNT} !== 5'b110_01) begin
         errors++;
         $display("FAIL press_edge5: level,pp,rp,count=%b required=11001",
                  {bif.LEVEL, bif.PRESS_PULSE, bif.RELEASE_PULSE, bif.PRESS_COUNT});
      end
      tick();
      vectors++;
      if ({bif.LEVEL, bif.PRESS_PULSE, bif.PRESS_COUNT} !== 4'b10_01) begin
         errors++;
         $display("FAIL press_edge6: level,pp,count=%b required=1001", {bif.LEVEL, bif.PRESS_PULSE, bif.PRESS_COUNT});
      end
      bif.BUTTON = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if ({bif.LEVEL, bif.RELEASE_PULSE} !== 2'b10) begin
            errors++;
            $display("FAIL release_early edge%0d: level,rp=%b required=10", i, {bif.LEVEL, bif.RELEASE_PULSE});
         end
      end
      tick();
      vectors++;
      if ({bif.LEVEL, bif.RELEASE_PULSE, bif.PRESS_PULSE, bif.PRESS_COUNT} !== 5'b010_01) begin
         errors++;
         $display("FAIL release_edge5: level,rp,pp,count=%b required=01001",
                  {bif.LEVEL, bif.RELEASE_PULSE, bif.PRESS_PULSE, bif.PRESS_COUNT});
      end
      tick();
      vectors++;
      if (bif.RELEASE_PULSE !== 1'b0) begin
         errors++;
         $display("FAIL release_edge6: rp=%b required=0", bif.RELEASE_PULSE);
      end
   endtask

   task automatic test_bounce;
      logic [16:0] pat;
      pat = 17'b1110111_0000000000;
      do_reset();
      for (int i = 16; i >= 0; i--) begin
         bif.BUTTON = pat[i];
         tick();
         vectors++;
         if ({bif.LEVEL, bif.PRESS_PULSE, bif.RELEASE_PULSE} !== 3'b000) begin
            errors++;
            $display("FAIL bounce step%0d: level,pp,rp=%b required=000", 16 - i,
                     {bif.LEVEL, bif.PRESS_PULSE, bif.RELEASE_PULSE});
         end
      end
      vectors++;
      if (bif.PRESS_COUNT !== 2'd0) begin
         errors++;
         $display("FAIL bounce_count: count=%0d required=0", bif.PRESS_COUNT);
      end
   endtask

   task automatic test_long_press;
      do_reset();
      press();
      for (int i = 1; i <= 20; i++) begin
         tick();
         vectors++;
         if (bif.LONG_PRESS !== (i >= 10)) begin
            errors++;
            $display("FAIL long_hold edge+%0d: long=%b required=%b", i, bif.LONG_PRESS, (i >= 10));
         end
      end
      bif.BUTTON = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if ({bif.LEVEL, bif.LONG_PRESS, bif.RELEASE_PULSE} !== 3'b110) begin
            errors++;
            $display("FAIL long_release_early edge%0d: level,long,rp=%b required=110", i,
                     {bif.LEVEL, bif.LONG_PRESS, bif.RELEASE_PULSE});
         end
      end
      tick();
      vectors++;
      if ({bif.LEVEL, bif.LONG_PRESS, bif.RELEASE_PULSE} !== 3'b001) begin
         errors++;
         $display("FAIL long_release_edge5: level,long,rp=%b required=001",
                  {bif.LEVEL, bif.LONG_PRESS, bif.RELEASE_PULSE});
      end
      tick();
      vectors++;
      if ({bif.LEVEL, bif.LONG_PRESS, bif.RELEASE_PULSE} !== 3'b000) begin
         errors++;
         $display("FAIL long_release_edge6: level,long,rp=%b required=000",
                  {bif.LEVEL, bif.LONG_PRESS, bif.RELEASE_PULSE});
      end
   endtask

   task automatic test_wrap;
      logic [1:0] exp_cnt [5];
      int         pulses;
      exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      do_reset();
      for (int p = 0; p < 5; p++) begin
         pulses = 0;
         bif.BUTTON = 1'b1;
         repeat (7) begin
            tick();
            pulses += int'(bif.PRESS_PULSE);
         end
         vectors++;
         if (bif.PRESS_COUNT !== exp_cnt[p]) begin
            errors++;
            $display("FAIL wrap_count press%0d: count=%0d required=%0d", p, bif.PRESS_COUNT, exp_cnt[p]);
         end
         bif.BUTTON = 1'b0;
         repeat (7) begin
            tick();
            pulses += int'(bif.PRESS_PULSE);
         end
         vectors++;
         if (pulses != 1) begin
            errors++;
            $display("FAIL wrap_pulses press%0d: pulses=%0d required=1", p, pulses);
         end
      end
   endtask

   task automatic test_reset_mid_hold;
      do_reset();
      press();
      repeat (10) tick();
      vectors++;
      if (bif.LONG_PRESS !== 1'b1) begin
         errors++;
         $display("FAIL midhold_long: long=%b required=1", bif.LONG_PRESS);
      end
      #2 RESET = 1'b0;
      #1;
      vectors++;
      if ({bif.LEVEL, bif.PRESS_PULSE, bif.RELEASE_PULSE, bif.LONG_PRESS, bif.PRESS_COUNT} !== 6'b0) begin
         errors++;
         $display("FAIL midhold_async: outputs=%b required=000000",
                  {bif.LEVEL, bif.PRESS_PULSE, bif.RELEASE_PULSE, bif.LONG_PRESS, bif.PRESS_COUNT});
      end
      tick();
      RESET = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         vectors++;
         if (i < 6) begin
            if ({bif.LEVEL, bif.PRESS_PULSE, bif.RELEASE_PULSE} !== 3'b000) begin
               errors++;
               $display("FAIL midhold_redebounce edge%0d: level,pp,rp=%b required=000", i,
                        {bif.LEVEL, bif.PRESS_PULSE, bif.RELEASE_PULSE});
            end
         end else if ({bif.LEVEL, bif.PRESS_PULSE, bif.PRESS_COUNT} !== 4'b11_01) begin
            errors++;
            $display("FAIL midhold_repress: level,pp,count=%b required=1101",
                     {bif.LEVEL, bif.PRESS_PULSE, bif.PRESS_COUNT});
         end
      end
   endtask

   task automatic test_release_bounce;
      logic [9:0] pat;
      pat = 10'b0001000000;
      do_reset();
      press();
      repeat (12) tick();
      for (int i = 9; i >= 1; i--) begin
         bif.BUTTON = pat[i];
         tick();
         vectors++;
         if ({bif.LEVEL, bif.LONG_PRESS, bif.RELEASE_PULSE} !== 3'b110) begin
            errors++;
            $display("FAIL relbounce step%0d: level,long,rp=%b required=110", 9 - i,
                     {bif.LEVEL, bif.LONG_PRESS, bif.RELEASE_PULSE});
         end
      end
      bif.BUTTON = pat[0];
      tick();
      vectors++;
      if ({bif.LEVEL, bif.LONG_PRESS, bif.RELEASE_PULSE} !== 3'b001) begin
         errors++;
         $display("FAIL relbounce_accept: level,long,rp=%b required=001",
                  {bif.LEVEL, bif.LONG_PRESS, bif.RELEASE_PULSE});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bif.BUTTON = 1'b0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_long_press();
      test_wrap();
      test_reset_mid_hold();
      test_release_bounce();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
